// File: rtl/if_pipe_stage_pkg.sv
// Shared constants for the instruction-fetch stage and its IF/ID register.
package if_pipe_stage_pkg;

  localparam int unsigned PC_W_DEFAULT    = 10;
  localparam int unsigned IMEM_AW_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT   = 16;
  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned RESET_PC        = 0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/if_pipe_stage_if.sv
// Fetch-stage bus: ID redirects and stall in, imem port, IF/ID register and debug counters out.
interface if_pipe_stage_if
  import if_pipe_stage_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEFAULT,
  parameter int unsigned IMEM_AW = IMEM_AW_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
);

  logic               Data_Hazard;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_address;
  logic               jump;
  logic [PC_W-1:0]    jump_address;
  logic [INSTR_W-1:0] imem_rdata;
  logic [IMEM_AW-1:0] imem_addr;
  logic [PC_W-1:0]    pc_plus4;
  logic [INSTR_W-1:0] instr;
  logic               if_id_valid;
  logic               Control_Hazard;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   flush_count;

  modport master (
    input  Data_Hazard, branch_taken, branch_address, jump, jump_address, imem_rdata,
    output imem_addr, pc_plus4, instr, if_id_valid, Control_Hazard, stall_count, flush_count
  );

  modport slave (
    output Data_Hazard, branch_taken, branch_address, jump, jump_address, imem_rdata,
    input  imem_addr, pc_plus4, instr, if_id_valid, Control_Hazard, stall_count, flush_count
  );

endinterface

// File: rtl/if_pipe_stage_if_id_pipe_reg.sv
// IF/ID pipeline register: hold on stall, bubble on flush, otherwise load the fetched word.
module if_id_pipe_reg
  import if_pipe_stage_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc_plus4_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc_plus4,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  logic [PC_W-1:0]    pc_plus4_q, pc_plus4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  // Stall outranks flush so a redirect seen during a stall is re-resolved later.
  always_comb begin
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (!stall) begin
      if (flush) begin
        pc_plus4_d = '0;
        instr_d    = NOP_INSTR;
        valid_d    = 1'b0;
      end else begin
        pc_plus4_d = pc_plus4_in;
        instr_d    = instr_in;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_plus4 = pc_plus4_q;
  assign instr    = instr_q;
  assign valid    = valid_q;

endmodule

// File: rtl/if_pipe_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register and debug counters.
module if_pipe_stage
  import if_pipe_stage_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEFAULT,
  parameter int unsigned IMEM_AW = IMEM_AW_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  if_pipe_stage_if.master  bus
);

  logic [PC_W-1:0]  pc_q, pc_d, pc_inc_c;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_c, flush_c;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus.branch_address[1:0], bus.jump_address[1:0]};

  always_comb begin
    stall_c  = ~bus.Data_Hazard;
    flush_c  = (bus.branch_taken | bus.jump) & bus.Data_Hazard;
    pc_inc_c = pc_q + PC_W'(4);
  end

  // Branch beats jump; targets are word-aligned by dropping the low two bits.
  always_comb begin
    pc_d = pc_q;
    if (!stall_c) begin
      if (bus.branch_taken) begin
        pc_d = {bus.branch_address[PC_W-1:2], 2'b00};
      end else if (bus.jump) begin
        pc_d = {bus.jump_address[PC_W-1:2], 2'b00};
      end else begin
        pc_d = pc_inc_c;
      end
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= PC_W'(RESET_PC);
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_pipe_reg #(.PC_W(PC_W)) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall_c),
    .flush       (flush_c),
    .pc_plus4_in (pc_inc_c),
    .instr_in    (bus.imem_rdata),
    .pc_plus4    (bus.pc_plus4),
    .instr       (bus.instr),
    .valid       (bus.if_id_valid)
  );

  assign bus.imem_addr      = pc_q[IMEM_AW+1:2];
  assign bus.Control_Hazard = flush_c;
  assign bus.stall_count    = stall_cnt_q;
  assign bus.flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_if_pipe_stage.sv
// Directed bench for if_pipe_stage; imem word n holds n+1, counters narrowed to 4 bits to reach saturation.
module tb_if_pipe_stage;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned IMEM_AW = 8;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  if_pipe_stage_if #(.PC_W(PC_W), .IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) bus ();

  if_pipe_stage #(.PC_W(PC_W), .IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.imem_rdata = 32'(bus.imem_addr) + 32'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [9:0] pp4,
                            input logic vld);
    check({tag, ".instr"},    64'(bus.instr),       64'(ins));
    check({tag, ".pc_plus4"}, 64'(bus.pc_plus4),    64'(pp4));
    check({tag, ".valid"},    64'(bus.if_id_valid), 64'(vld));
  endtask

  initial begin
    reset              = 1'b1;
    bus.Data_Hazard    = 1'b1;
    bus.branch_taken   = 1'b0;
    bus.branch_address = '0;
    bus.jump           = 1'b0;
    bus.jump_address   = '0;
    tick();
    check("rst.imem_addr", 64'(bus.imem_addr), 64'd0);
    check_ifid("rst", 32'h0, 10'd0, 1'b0);
    check("rst.stall_count", 64'(bus.stall_count), 64'd0);
    check("rst.flush_count", 64'(bus.flush_count), 64'd0);
    reset = 1'b0;

    // Free run: addr 0,1,2 then stall at pc=8.
    #1;
    check("run0.imem_addr", 64'(bus.imem_addr), 64'd0);
    tick();
    check("run1.imem_addr", 64'(bus.imem_addr), 64'd1);
    check_ifid("run1", 32'd1, 10'd4, 1'b1);
    tick();
    check("run2.imem_addr", 64'(bus.imem_addr), 64'd2);
    check_ifid("run2", 32'd2, 10'd8, 1'b1);

    // Two-cycle stall with a branch that must be ignored.
    bus.Data_Hazard    = 1'b0;
    bus.branch_taken   = 1'b1;
    bus.branch_address = 10'd64;
    #1;
    check("stall.ctrl_hz", 64'(bus.Control_Hazard), 64'd0);
    for (int i = 0; i < 2; i++) tick();
    check("stall.imem_addr", 64'(bus.imem_addr), 64'd2);
    check_ifid("stall", 32'd2, 10'd8, 1'b1);
    check("stall.stall_count", 64'(bus.stall_count), 64'd2);
    check("stall.flush_count", 64'(bus.flush_count), 64'd0);
    bus.Data_Hazard  = 1'b1;
    bus.branch_taken = 1'b0;
    tick();
    check("run3.imem_addr", 64'(bus.imem_addr), 64'd3);
    check_ifid("run3", 32'd3, 10'd12, 1'b1);

    // Taken branch at pc=12 to 64.
    bus.branch_taken   = 1'b1;
    bus.branch_address = 10'd64;
    #1;
    check("br.ctrl_hz", 64'(bus.Control_Hazard), 64'd1);
    tick();
    bus.branch_taken = 1'b0;
    check("br.imem_addr", 64'(bus.imem_addr), 64'd16);
    check_ifid("br.flush", 32'h0, 10'd0, 1'b0);
    check("br.flush_count", 64'(bus.flush_count), 64'd1);
    tick();
    check_ifid("br.target", 32'd17, 10'd68, 1'b1);
    check("br.imem_addr2", 64'(bus.imem_addr), 64'd17);

    // Branch and jump together: branch wins, one flush.
    bus.branch_taken   = 1'b1;
    bus.branch_address = 10'd64;
    bus.jump           = 1'b1;
    bus.jump_address   = 10'd200;
    #1;
    check("both.ctrl_hz", 64'(bus.Control_Hazard), 64'd1);
    tick();
    bus.branch_taken = 1'b0;
    check("both.imem_addr", 64'(bus.imem_addr), 64'd16);
    check("both.flush_count", 64'(bus.flush_count), 64'd2);

    // Back-to-back redirect: jump to unaligned 1023 lands on 1020.
    bus.jump_address = 10'd1023;
    tick();
    bus.jump = 1'b0;
    check("jmp.imem_addr", 64'(bus.imem_addr), 64'd255);
    check_ifid("jmp.flush", 32'h0, 10'd0, 1'b0);
    check("jmp.flush_count", 64'(bus.flush_count), 64'd3);

    // PC wrap from 1020.
    tick();
    check("wrap.imem_addr", 64'(bus.imem_addr), 64'd0);
    check_ifid("wrap", 32'd256, 10'd0, 1'b1);

    // Long stall with jump pending: counter saturates, no flush counted.
    bus.Data_Hazard  = 1'b0;
    bus.jump         = 1'b1;
    bus.jump_address = 10'd200;
    for (int i = 0; i < 17; i++) tick();
    check("sat.stall_count", 64'(bus.stall_count), 64'd15);
    check("sat.flush_count", 64'(bus.flush_count), 64'd3);
    check("sat.imem_addr", 64'(bus.imem_addr), 64'd0);

    // Reset mid-stall with jump asserted.
    reset = 1'b1;
    tick();
    check("mrst.imem_addr", 64'(bus.imem_addr), 64'd0);
    check_ifid("mrst", 32'h0, 10'd0, 1'b0);
    check("mrst.stall_count", 64'(bus.stall_count), 64'd0);
    check("mrst.flush_count", 64'(bus.flush_count), 64'd0);
    check("mrst.ctrl_hz_lo", 64'(bus.Control_Hazard), 64'd0);
    bus.Data_Hazard = 1'b1;
    #1;
    check("mrst.ctrl_hz_hi", 64'(bus.Control_Hazard), 64'd1);
    tick();
    check("mrst2.imem_addr", 64'(bus.imem_addr), 64'd0);
    check("mrst2.flush_count", 64'(bus.flush_count), 64'd0);
    check("mrst2.valid", 64'(bus.if_id_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
